muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter WATCHDOG, default 16: maximum WAIT-state cycles before an operation is abandoned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 op_valid  input  1  pipeline presents an operation.
REQ-005 op  input  3  0 NOP, 1 MULT (signed), 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NOP).
REQ-006 op_a, op_b  input  32 each  source operands (rs, rt).
REQ-007 flush  input  1  abort any in-flight multiply.
REQ-008 op_ready  output  1  controller accepts an operation this cycle.
REQ-009 stall  output  1  pipeline hold request.
REQ-010 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-011 rd_data  output  32  MFHI/MFLO result.
REQ-012 hi, lo  output  32 each  architectural HI/LO registers.
REQ-013 busy  output  1  multiply in flight.
REQ-014 err  output  1  sticky watchdog-timeout flag.
REQ-015 mul_valid_in  output  1  start pulse to the unsigned multiplier.
REQ-016 mul_a, mul_b  output  32 each  multiplier operands, registered.
REQ-017 mul_valid_out  input  1  multiplier result valid.
REQ-018 mul_hi, mul_lo  input  32 each  multiplier 64-bit unsigned product.

Function
REQ-019 States: IDLE, ISSUE, WAIT, FIXUP; op_ready = (state==IDLE); busy = (state!=IDLE); stall = op_valid & ~op_ready.
REQ-020 Accept = op_valid & op_ready & ~flush; nothing is accepted in a cycle where flush=1.
REQ-021 MULTU accepted: mul_a=op_a, mul_b=op_b, neg=0; IDLE->ISSUE.
REQ-022 MULT accepted: mul_a=|op_a|, mul_b=|op_b| (two's-complement magnitude, 0x80000000 maps to 0x80000000 unsigned), neg=op_a[31]^op_b[31]; IDLE->ISSUE.
REQ-023 ISSUE: mul_valid_in=1 for exactly this cycle; ISSUE->WAIT; mul_valid_in=0 in all other states.
REQ-024 mul_valid_out is sampled only in WAIT and ignored in every other state, including a level held high from a previous operation.
REQ-025 WAIT with mul_valid_out=1: capture {mul_hi,mul_lo} into a 64-bit result register; WAIT->FIXUP.
REQ-026 FIXUP: {hi,lo} <= neg ? (~result+1) mod 2^64 : result; FIXUP->IDLE; issue-to-HI/LO-update latency = multiplier latency + 3 cycles.
REQ-027 MTHI/MTLO accepted in IDLE: hi (resp. lo) <= op_a at that edge; state stays IDLE.
REQ-028 MFHI/MFLO accepted in IDLE: next cycle rd_valid=1, rd_data = hi (resp. lo) as it was at the accept edge.
REQ-029 MFHI/MFLO/MTHI/MTLO presented while busy are not accepted; stall=1 until FIXUP completes; the read then returns the new product.
REQ-030 NOP/reserved accepted: no state change, no rd_valid.
REQ-031 Watchdog: a counter clears on WAIT entry and increments each WAIT cycle; when it reaches WATCHDOG without mul_valid_out, err<=1, WAIT->IDLE, hi/lo unchanged.
REQ-032 flush in ISSUE, WAIT or FIXUP: next state IDLE; hi/lo unchanged; mul_valid_in forced 0; a later mul_valid_out is ignored per REQ-024.
REQ-033 mul_valid_out and flush in the same WAIT cycle: flush wins, no capture.
REQ-034 A new op may be accepted the first cycle back in IDLE (back-to-back multiplies permitted).

Reset
REQ-035 reset_n=0 immediately forces: state IDLE, hi=lo=0, rd_valid=0, rd_data=0, mul_valid_in=0, mul_a=mul_b=0, err=0, watchdog counter 0, neg=0.
REQ-036 Reset mid-operation discards the operation; after release the first mul_valid_out is ignored until a new ISSUE.
REQ-037 err clears only on reset.

Verification
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> mul_valid_in one pulse; hi=0xFFFFFFFE, lo=0x00000001; busy low afterwards.
REQ-039 MULT -3 x 7 -> mul_a=3, mul_b=7; hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-040 MULT issued, MFLO presented next cycle -> stall=1 until FIXUP; rd_data = new lo, rd_valid one pulse.
REQ-041 MTHI 0x1234, MFHI -> rd_data=0x1234 one cycle after the MFHI accept.
REQ-042 flush during WAIT, multiplier then asserts mul_valid_out -> hi/lo unchanged, state IDLE; stuck-low mul_valid_out -> err=1 after 16 WAIT cycles.
REQ-043 reset_n low during WAIT -> all outputs at reset values asynchronously; the stale mul_valid_out after release has no effect.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide-unit controller: sequences signed/unsigned multiplies through an
// external unsigned multiplier and serves MTHI/MTLO/MFHI/MFLO against the architectural HI/LO.
module muldiv_ctrl #(
  parameter int unsigned WATCHDOG = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err,
  output logic        mul_valid_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_valid_out,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);

  localparam int unsigned WDW = $clog2(WATCHDOG + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIXUP} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_RSVD
  } op_e;

  state_e         state, state_nx;
  op_e            op_dec;
  logic           accept;
  logic           is_mul;
  logic           wd_expire;
  logic [WDW-1:0] wd_cnt;
  logic           neg;
  logic [63:0]    result;
  logic [31:0]    mag_a, mag_b;

  assign op_dec    = op_e'(op);
  assign accept    = op_valid & op_ready & ~flush;
  assign is_mul    = (op_dec == OP_MULT) || (op_dec == OP_MULTU);
  assign wd_expire = (wd_cnt == WDW'(WATCHDOG - 1));
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign mag_a     = op_a[31] ? (~op_a + 32'd1) : op_a;
  assign mag_b     = op_b[31] ? (~op_b + 32'd1) : op_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept && is_mul) state_nx = ISSUE;
      ISSUE: state_nx = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)              state_nx = IDLE;
        else if (mul_valid_out) state_nx = FIXUP;
        else if (wd_expire)     state_nx = IDLE;
      end
      FIXUP: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_ready     = (state == IDLE);
    busy         = (state != IDLE);
    stall        = op_valid & (state != IDLE);
    mul_valid_in = (state == ISSUE) & ~flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      err      <= 1'b0;
      wd_cnt   <= '0;
      neg      <= 1'b0;
      result   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        case (op_dec)
          OP_MULT: begin
            mul_a <= mag_a;
            mul_b <= mag_b;
            neg   <= op_a[31] ^ op_b[31];
          end
          OP_MULTU: begin
            mul_a <= op_a;
            mul_b <= op_b;
            neg   <= 1'b0;
          end
          OP_MTHI: hi <= op_a;
          OP_MTLO: lo <= op_a;
          OP_MFHI: begin
            rd_valid <= 1'b1;
            rd_data  <= hi;
          end
          OP_MFLO: begin
            rd_valid <= 1'b1;
            rd_data  <= lo;
          end
          default: ;
        endcase
      end
      // ISSUE always precedes WAIT, so clearing here zeroes the count on WAIT entry
      if (state == ISSUE) wd_cnt <= '0;
      if (state == WAIT && !flush) begin
        if (mul_valid_out)  result <= {mul_hi, mul_lo};
        else if (wd_expire) err    <= 1'b1;
        else                wd_cnt <= wd_cnt + 1'b1;
      end
      if (state == FIXUP && !flush) {hi, lo} <= neg ? (~result + 64'd1) : result;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, hand-written corner sequences and a
// randomized run against a signed/unsigned arithmetic model of HI/LO.
module tb_muldiv_ctrl;

  localparam int unsigned WD = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        op_ready, stall, rd_valid, busy, err, mul_valid_in;
  logic [31:0] rd_data, hi, lo, mul_a, mul_b;
  logic        mul_valid_out;
  logic [31:0] mul_hi, mul_lo;

  // Multiplier stand-in: automatic mode returns the product after mul_lat cycles,
  // manual mode lets sequences drive mul_valid_out directly.
  logic        mul_auto;
  int          mul_lat;
  int          cd = 0;
  int          pulses = 0;
  logic [63:0] pend_prod = '0;
  logic        man_v;
  logic [31:0] man_hi, man_lo;

  logic [31:0] mdl_hi, mdl_lo;
  int          checks = 0;
  int          errors = 0;

  muldiv_ctrl #(.WATCHDOG(WD)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .op_ready(op_ready), .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .err(err), .mul_valid_in(mul_valid_in), .mul_a(mul_a),
    .mul_b(mul_b), .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_valid_in) pulses <= pulses + 1;
    if (mul_valid_in && mul_auto) begin
      cd        <= mul_lat;
      pend_prod <= {32'd0, mul_a} * {32'd0, mul_b};
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
  end

  assign mul_valid_out = mul_auto ? (cd == 1) : man_v;
  assign mul_hi        = mul_auto ? pend_prod[63:32] : man_hi;
  assign mul_lo        = mul_auto ? pend_prod[31:0]  : man_lo;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, mula, mulb, exp_hi, exp_lo;
    int          lat;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_mag(input logic sgn, input logic [31:0] a);
    return (sgn && a[31]) ? (32'd0 - a) : a;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Present an op until accepted; returns at the falling edge after the accepting edge.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int waits);
    bit ok = 0;
    waits = 0;
    op_valid = 1'b1; op = o; op_a = a; op_b = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (op_ready) ok = 1;
      else begin
        chk("stall_while_busy", 64'(stall), 64'd1);
        waits++;
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    bit done = 0;
    cyc = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (!busy) done = 1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] ema, input logic [31:0] emb, input logic [63:0] exp);
    int w, cyc, p0;
    mul_auto = 1'b1; mul_lat = lat; p0 = pulses;
    drive_op(sgn ? 3'd1 : 3'd2, a, b, w);
    #1;
    chk("issue_pulse", 64'(mul_valid_in), 64'd1);
    chk("mul_a", 64'(mul_a), 64'(ema));
    chk("mul_b", 64'(mul_b), 64'(emb));
    wait_idle(cyc);
    chk("busy_cycles", 64'(cyc), 64'(lat + 2));
    chk("mult_hi", 64'(hi), 64'(exp[63:32]));
    chk("mult_lo", 64'(lo), 64'(exp[31:0]));
    chk("issue_pulse_count", 64'(pulses - p0), 64'd1);
    mdl_hi = exp[63:32];
    mdl_lo = exp[31:0];
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, cyc, p0;
    logic [2:0]  o;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'hFFFF_FFFC, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 5};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 4};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 2};

    reset_n = 1'b0; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0; flush = 1'b0;
    mul_auto = 1'b1; mul_lat = 1; man_v = 1'b0; man_hi = '0; man_lo = '0;
    mdl_hi = '0; mdl_lo = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed multiply table, issued back to back
    for (int i = 0; i < 7; i++)
      do_mult(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].mula, vecs[i].mulb,
              {vecs[i].exp_hi, vecs[i].exp_lo});

    // MTHI/MFHI and MTLO/MFLO
    drive_op(3'd3, 32'h0000_1234, 32'd0, w);
    #1 chk("mthi_hi", 64'(hi), 64'h1234);
    drive_op(3'd5, 32'd0, 32'd0, w);
    #1;
    chk("mfhi_rd_valid", 64'(rd_valid), 64'd1);
    chk("mfhi_rd_data", 64'(rd_data), 64'h1234);
    @(negedge clk);
    #1 chk("mfhi_pulse_end", 64'(rd_valid), 64'd0);
    drive_op(3'd4, 32'h0000_A5A5, 32'd0, w);
    drive_op(3'd6, 32'd0, 32'd0, w);
    #1 chk("mflo_rd_data", 64'(rd_data), 64'hA5A5);
    mdl_hi = 32'h1234; mdl_lo = 32'hA5A5;

    // MFLO presented while a MULT is in flight returns the new product
    mul_auto = 1'b1; mul_lat = 3;
    drive_op(3'd1, 32'hFFFF_FFF9, 32'd6, w);
    drive_op(3'd6, 32'd0, 32'd0, w);
    chk("mflo_stall_cycles", 64'(w), 64'd5);
    #1;
    chk("mflo_busy_rd_valid", 64'(rd_valid), 64'd1);
    chk("mflo_busy_rd_data", 64'(rd_data), 64'hFFFF_FFD6);
    chk("mflo_busy_hi", 64'(hi), 64'hFFFF_FFFF);
    @(negedge clk);
    #1 chk("mflo_busy_pulse_end", 64'(rd_valid), 64'd0);
    mdl_hi = 32'hFFFF_FFFF; mdl_lo = 32'hFFFF_FFD6;

    // Flush in ISSUE suppresses the start pulse
    mul_auto = 1'b0; p0 = pulses;
    drive_op(3'd2, 32'd7, 32'd9, w);
    flush = 1'b1;
    #1 chk("flush_issue_no_pulse", 64'(mul_valid_in), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_issue_idle", 64'(busy), 64'd0);
    chk("flush_issue_pulses", 64'(pulses - p0), 64'd0);

    // Flush in WAIT, then a late result is ignored
    drive_op(3'd1, 32'd11, 32'd13, w);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_wait_busy", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b0; man_v = 1'b1; man_hi = 32'hDEAD_DEAD; man_lo = 32'hBEEF_BEEF;
    repeat (3) @(negedge clk);
    #1;
    chk("late_valid_busy", 64'(busy), 64'd0);
    chk("late_valid_hi", 64'(hi), 64'(mdl_hi));
    chk("late_valid_lo", 64'(lo), 64'(mdl_lo));
    man_v = 1'b0;

    // Flush and result in the same WAIT cycle: flush wins
    drive_op(3'd2, 32'd11, 32'd13, w);
    @(negedge clk);
    flush = 1'b1; man_v = 1'b1;
    @(negedge clk);
    flush = 1'b0; man_v = 1'b0;
    #1;
    chk("flush_win_busy", 64'(busy), 64'd0);
    chk("flush_win_hi", 64'(hi), 64'(mdl_hi));
    chk("flush_win_lo", 64'(lo), 64'(mdl_lo));

    // Result level held through IDLE/ISSUE is only honoured once in WAIT
    man_v = 1'b1; man_hi = 32'h0BAD_0BAD; man_lo = 32'h0BAD_0BAD;
    drive_op(3'd2, 32'd3, 32'd5, w);
    man_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    man_v = 1'b1; man_hi = 32'd0; man_lo = 32'd15;
    @(negedge clk);
    man_v = 1'b0;
    wait_idle(cyc);
    chk("held_valid_fixup_cycles", 64'(cyc), 64'd1);
    chk("held_valid_hi", 64'(hi), 64'd0);
    chk("held_valid_lo", 64'(lo), 64'd15);
    mdl_hi = 32'd0; mdl_lo = 32'd15;

    // Watchdog on a stuck multiplier; err is sticky
    chk("err_before_wd", 64'(err), 64'd0);
    drive_op(3'd1, 32'd2, 32'd3, w);
    wait_idle(cyc);
    chk("wd_busy_cycles", 64'(cyc), 64'(WD + 1));
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_hi", 64'(hi), 64'(mdl_hi));
    chk("wd_lo", 64'(lo), 64'(mdl_lo));
    do_mult(1'b0, 32'd2, 32'd3, 2, 32'd2, 32'd3, 64'd6);
    chk("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset during WAIT
    drive_op(3'd3, 32'h55, 32'd0, w);
    drive_op(3'd6, 32'd0, 32'd0, w);
    mul_auto = 1'b1; mul_lat = 5;
    drive_op(3'd2, 32'd4, 32'd4, w);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    chk("arst_mul_valid_in", 64'(mul_valid_in), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; mdl_hi = '0; mdl_lo = '0;
    mul_auto = 1'b0; man_v = 1'b1; man_hi = 32'h1111_2222; man_lo = 32'h3333_4444;
    repeat (4) @(negedge clk);
    #1;
    chk("stale_busy", 64'(busy), 64'd0);
    chk("stale_hi", 64'(hi), 64'd0);
    chk("stale_lo", 64'(lo), 64'd0);
    man_v = 1'b0;
    @(negedge clk);

    // Randomized ops against the arithmetic model
    for (int n = 0; n < 200; n++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      case (o)
        3'd1, 3'd2:
          do_mult(o == 3'd1, a, b, $urandom_range(1, 6), ref_mag(o == 3'd1, a),
                  ref_mag(o == 3'd1, b), ref_prod(o == 3'd1, a, b));
        3'd3, 3'd4: begin
          drive_op(o, a, b, w);
          if (o == 3'd3) mdl_hi = a;
          else           mdl_lo = a;
          #1;
          chk("rnd_mt_hi", 64'(hi), 64'(mdl_hi));
          chk("rnd_mt_lo", 64'(lo), 64'(mdl_lo));
        end
        3'd5, 3'd6: begin
          drive_op(o, a, b, w);
          #1;
          chk("rnd_mf_valid", 64'(rd_valid), 64'd1);
          chk("rnd_mf_data", 64'(rd_data), 64'((o == 3'd5) ? mdl_hi : mdl_lo));
        end
        default: begin
          drive_op(o, a, b, w);
          #1;
          chk("rnd_nop_rd_valid", 64'(rd_valid), 64'd0);
          chk("rnd_nop_busy", 64'(busy), 64'd0);
          chk("rnd_nop_hi", 64'(hi), 64'(mdl_hi));
          chk("rnd_nop_lo", 64'(lo), 64'(mdl_lo));
        end
      endcase
    end
    chk("final_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
